gcd_lcm_sequencer: RTL and testbench
====================================

Name: gcd_lcm_sequencer

Overview:
- Multi-cycle coprocessor engine for the single-cycle RISC-V core.
- Computes GCD by subtractive Euclid, or LCM by alternating-accumulate (no divider).
- Launched by the core's Start strobe; holds the core via `stall` while iterating.
- Returns the result with a one-cycle `done` pulse for register writeback.

Parameters:
- WIDTH, 32, operand/result width in bits.
- MAX_ITER, 4096, maximum update steps before timeout error; iteration counter is $clog2(MAX_ITER+1) bits.

Ports:
- clk      input   1      clock; all state updates on rising edge
- reset    input   1      synchronous, active-high
- start    input   1      launch request from core decode; sampled only in IDLE
- op       input   1      0 = GCD, 1 = LCM; latched with start
- opa      input   WIDTH  operand A; latched with start
- opb      input   WIDTH  operand B; latched with start
- busy     output  1      state != IDLE
- stall    output  1      combinational: (state==RUN) | (state==IDLE & start); core holds PC while high
- done     output  1      one-cycle pulse, high exactly in DONE state
- result   output  WIDTH  final value; held until the next accepted start
- err      output  1      overflow/timeout flag for the last operation; held with result

Behaviour:
- Reset (sync, active-high): state=IDLE; result=0, err=0, done=0, busy=0; x, y, iter cleared. Reset in any state aborts the operation with no done pulse.
- States and transitions:
  - IDLE: on start=1, latch op, x=opa, y=opb, iter=0; clear result and err; go to RUN.
  - RUN: one decision per cycle, applied in strict priority order:
    1. x==0 or y==0 → DONE. GCD result = x|y (the nonzero operand, 0 if both zero). LCM result = 0.
    2. x==y → DONE, result=x.
    3. iter==MAX_ITER → DONE, err=1, result=0.
    4. GCD: if x>y then x=x-y, else y=y-x; iter++.
    5. LCM: if x<y then x=x+A, else y=y+B. A and B are the latched operands. The addition is WIDTH+1 bits wide. On carry-out → DONE, err=1, result=0, x/y unchanged. Otherwise update and iter++.
  - DONE: done=1 for this cycle only; then go to IDLE unconditionally.
- start handling:
  - start is ignored in RUN and DONE; there is no queuing.
  - start during the DONE cycle is ignored and stall stays low; the core must reissue it.
- Latency: start sampled in cycle 0. With N update steps, done is high in cycle N+2. Zero operand: done in cycle 2.
- Unsigned arithmetic throughout; GCD subtraction never underflows, because the smaller value is always subtracted from the larger.
- Outputs are registered except stall.
- result and err are stable from the DONE cycle until the next accepted start.

Test Plan:
- GCD(12,8): start cycle 0 → x/y go 12/8, 4/8, 4/4; done=1 in cycle 4 only, result=4, err=0; stall high cycles 0–3, low in cycle 4.
- LCM(4,6): → x/y go 4/6, 8/6, 8/12, 12/12; done in cycle 5, result=12, err=0. Back-to-back GCD(9,6) started in cycle 6 → result=3.
- Zero operands: GCD(7,0) → result=7, done cycle 2. GCD(0,0) → 0. LCM(0,5) → 0, err=0. start asserted while busy has no effect on result.
- Overflow (WIDTH=8): LCM(255,254) → y+254 carries in cycle 1; done cycle 2, err=1, result=0.
- Timeout (MAX_ITER=16): GCD(1,100) → 16 updates; done cycle 18, err=1, result=0.
- Reset mid-op: assert reset in cycle 2 of GCD(12,8) → next cycle busy=0, done never pulses, result=0, err=0. A fresh start then completes normally.

Source files
------------

// File: rtl/gcd_lcm_sequencer_if.sv
// Core <-> GCD/LCM engine handshake bundle.
// The core drives launch fields; the engine returns status and result.
interface gcd_lcm_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    output start, op, opa, opb,
    input  busy, stall, done, result, err
  );

  modport slave (
    input  start, op, opa, opb,
    output busy, stall, done, result, err
  );
endinterface

// File: rtl/gcd_lcm_sequencer.sv
// Multi-cycle GCD (subtractive Euclid) / LCM (alternating accumulate)
// engine that stalls the core while it iterates.
module gcd_lcm_sequencer #(
  parameter int WIDTH    = 32,
  parameter int MAX_ITER = 4096
) (
  input  logic               clk,
  input  logic               reset,
  gcd_lcm_sequencer_if.slave bus
);
  localparam int IW = $clog2(MAX_ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   sum;
  logic             fin;
  logic             fin_err;
  logic [WIDTH-1:0] fin_res;
  logic [WIDTH-1:0] nx;
  logic [WIDTH-1:0] ny;

  // One RUN decision: finish (with result/err) or the next x/y step
  always_comb begin
    sum     = '0;
    fin     = 1'b0;
    fin_err = 1'b0;
    fin_res = '0;
    nx      = x_q;
    ny      = y_q;
    if (x_q == '0 || y_q == '0) begin
      fin     = 1'b1;
      fin_res = op_q ? '0 : (x_q | y_q);
    end else if (x_q == y_q) begin
      fin     = 1'b1;
      fin_res = x_q;
    end else if (iter_q == IW'(MAX_ITER)) begin
      fin     = 1'b1;
      fin_err = 1'b1;
    end else if (!op_q) begin
      if (x_q > y_q) nx = x_q - y_q;
      else           ny = y_q - x_q;
    end else begin
      if (x_q < y_q) sum = {1'b0, x_q} + {1'b0, a_q};
      else           sum = {1'b0, y_q} + {1'b0, b_q};
      if (sum[WIDTH]) begin
        fin     = 1'b1;
        fin_err = 1'b1;
      end else if (x_q < y_q) begin
        nx = sum[WIDTH-1:0];
      end else begin
        ny = sum[WIDTH-1:0];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (fin)       state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: latch operands on launch, step or finish while running
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    x_d      = x_q;
    y_d      = y_q;
    iter_d   = iter_q;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d     = bus.op;
          a_d      = bus.opa;
          b_d      = bus.opb;
          x_d      = bus.opa;
          y_d      = bus.opb;
          iter_d   = '0;
          result_d = '0;
          err_d    = 1'b0;
        end
      end
      S_RUN: begin
        if (fin) begin
          result_d = fin_res;
          err_d    = fin_err;
        end else begin
          x_d    = nx;
          y_d    = ny;
          iter_d = iter_q + IW'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered status outputs follow the next state
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      iter_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      x_q      <= x_d;
      y_q      <= y_d;
      iter_q   <= iter_d;
      result_q <= result_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;
  assign bus.stall  = (state_q == S_RUN) |
                      ((state_q == S_IDLE) & bus.start);
endmodule

// File: tb/tb_gcd_lcm_sequencer.sv
// Bench for gcd_lcm_sequencer: directed launches checked against a
// cycle-level behavioural model plus literal per-op expectations.
module tb_gcd_lcm_sequencer;
  localparam int W  = 8;
  localparam int MI = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk = 1'b0;

  gcd_lcm_sequencer_if #(.WIDTH(W)) bus ();

  gcd_lcm_sequencer #(
    .WIDTH   (W),
    .MAX_ITER(MI)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: result, err and number of update steps for one op
  function automatic void ref_op(input bit o, input int unsigned a,
                                 input int unsigned b,
                                 output int unsigned r,
                                 output bit e, output int n);
    longint unsigned x, y, lim;
    bit fin;
    x = a; y = b; lim = 64'd1 << W;
    r = 0; e = 0; n = 0; fin = 0;
    while (!fin) begin
      if (x == 0 || y == 0) begin
        r = o ? 0 : 32'(x | y); fin = 1;
      end else if (x == y) begin
        r = 32'(x); fin = 1;
      end else if (n == MI) begin
        e = 1; fin = 1;
      end else if (!o) begin
        if (x > y) x = x - y; else y = y - x;
        n++;
      end else if (x < y) begin
        if (x + a >= lim) begin e = 1; fin = 1; end
        else begin x = x + a; n++; end
      end else begin
        if (y + b >= lim) begin e = 1; fin = 1; end
        else begin y = y + b; n++; end
      end
    end
  endfunction

  // Cycle model: 0 idle, 1 running, 2 done
  int          m_st = 0;
  int          m_left = 0;
  int unsigned m_res = 0;
  bit          m_err = 0;
  int unsigned p_res = 0;
  bit          p_err = 0;
  int unsigned t_res;
  bit          t_err;
  int          t_n;

  always @(posedge clk) begin
    if (reset) begin
      m_st  <= 0;
      m_res <= 0;
      m_err <= 0;
    end else begin
      case (m_st)
        0: if (bus.start === 1'b1) begin
          ref_op(bus.op, 32'(bus.opa), 32'(bus.opb), t_res, t_err, t_n);
          p_res  <= t_res;
          p_err  <= t_err;
          m_left <= t_n + 1;
          m_st   <= 1;
          m_res  <= 0;
          m_err  <= 0;
        end
        1: begin
          if (m_left == 1) begin
            m_st  <= 2;
            m_res <= p_res;
            m_err <= p_err;
          end else begin
            m_left <= m_left - 1;
          end
        end
        default: m_st <= 0;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk) begin
      chk_eq("busy", 64'(bus.busy), 64'(m_st != 0));
      chk_eq("done", 64'(bus.done), 64'(m_st == 2));
      chk_eq("stall", 64'(bus.stall),
             64'(m_st == 1 || (m_st == 0 && bus.start)));
      chk_eq("result", 64'(bus.result), 64'(m_res));
      chk_eq("err", 64'(bus.err), 64'(m_err));
    end
  end

  task automatic run_op(input string nm, input bit o,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold, input int er, input bit ee,
                        input int ec);
    bit seen = 0;
    @(posedge clk); #1;
    bus.start = 1; bus.op = o; bus.opa = a; bus.opb = b;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (hold && k <= ec) begin
        bus.start = 1; bus.op = 1; bus.opa = 1; bus.opb = 1;
      end else begin
        bus.start = 0;
      end
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1;
        chk_eq({nm, ".cycle"}, 64'(k), 64'(ec));
        chk_eq({nm, ".result"}, 64'(bus.result), 64'(er));
        chk_eq({nm, ".err"}, 64'(bus.err), 64'(ee));
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s.timeout: no done within 40 cycles", nm);
    end
  endtask

  task automatic pin_ref(input string nm, input bit o,
                         input int unsigned a, input int unsigned b,
                         input int er, input bit ee, input int en);
    int unsigned r;
    bit e;
    int n;
    ref_op(o, a, b, r, e, n);
    chk_eq({nm, ".r"}, 64'(r), 64'(er));
    chk_eq({nm, ".e"}, 64'(e), 64'(ee));
    chk_eq({nm, ".n"}, 64'(n), 64'(en));
  endtask

  initial begin
    bus.start = 0; bus.op = 0; bus.opa = '0; bus.opb = '0;

    pin_ref("ref_gcd12_8", 0, 12, 8, 4, 0, 2);
    pin_ref("ref_lcm4_6", 1, 4, 6, 12, 0, 3);
    pin_ref("ref_ovf", 1, 255, 254, 0, 1, 0);
    pin_ref("ref_tmo", 0, 1, 100, 0, 1, 16);

    repeat (2) @(posedge clk);
    #1;
    chk = 1;
    reset = 0;
    @(negedge clk);
    chk_eq("rst.busy", 64'(bus.busy), 64'(0));
    chk_eq("rst.done", 64'(bus.done), 64'(0));
    chk_eq("rst.result", 64'(bus.result), 64'(0));
    chk_eq("rst.err", 64'(bus.err), 64'(0));

    run_op("gcd12_8", 0, 8'd12, 8'd8, 0, 4, 0, 4);
    run_op("lcm4_6", 1, 8'd4, 8'd6, 0, 12, 0, 5);
    run_op("gcd9_6", 0, 8'd9, 8'd6, 0, 3, 0, 4);
    run_op("gcd7_0", 0, 8'd7, 8'd0, 0, 7, 0, 2);
    run_op("gcd0_0", 0, 8'd0, 8'd0, 0, 0, 0, 2);
    run_op("lcm0_5", 1, 8'd0, 8'd5, 0, 0, 0, 2);
    run_op("busy_start", 0, 8'd12, 8'd8, 1, 4, 0, 4);
    run_op("ovf", 1, 8'd255, 8'd254, 0, 0, 1, 2);
    run_op("tmo", 0, 8'd1, 8'd100, 0, 0, 1, 18);

    @(posedge clk); #1;
    bus.start = 1; bus.op = 0; bus.opa = 8'd12; bus.opb = 8'd8;
    @(posedge clk); #1;
    bus.start = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk_eq("abort.busy", 64'(bus.busy), 64'(0));
    chk_eq("abort.result", 64'(bus.result), 64'(0));
    chk_eq("abort.err", 64'(bus.err), 64'(0));
    repeat (6) @(posedge clk);

    run_op("after_rst", 0, 8'd12, 8'd8, 0, 4, 0, 4);
    repeat (3) @(posedge clk);
    #1;
    chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
